// File: rtl/apu_pkg.sv
// apu_pkg: shared APU register offsets, noise enable bit, FSM state type and status helper
package apu_pkg;
  localparam logic [15:0] OFS_400C = 16'h000C;
  localparam logic [15:0] OFS_400E = 16'h000E;
  localparam logic [15:0] OFS_400F = 16'h000F;
  localparam logic [15:0] OFS_4015 = 16'h0015;
  localparam int NOISE_EN_BIT = 3;
  typedef enum logic {IDLE, RESP} state_t;
  function automatic logic [7:0] status_byte(input logic nz);
    return {4'b0, nz, 3'b0};
  endfunction
endpackage

// File: rtl/apu_noise_regs_if.sv
// apu_noise_regs_if: CPU valid/ready register bus between CPU (master) and register block (slave)
interface apu_noise_regs_if;
  logic        cpu_valid;
  logic        cpu_ready;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  modport master (output cpu_valid, cpu_we, cpu_addr, cpu_wdata, input cpu_ready, cpu_rdata, cpu_rvalid);
  modport slave (input cpu_valid, cpu_we, cpu_addr, cpu_wdata, output cpu_ready, cpu_rdata, cpu_rvalid);
endinterface

// File: rtl/apu_noise_regs.sv
// apu_noise_regs: CPU-side writer for noise channel registers with strobes, length pulses and $4015 status
module apu_noise_regs
  import apu_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h4000
) (
  input  logic              clk,
  input  logic              rst,
  apu_noise_regs_if.slave   bus,
  input  logic              noise_len_nz,
  output logic [7:0]        r400c,
  output logic [7:0]        r400e,
  output logic [7:0]        r400f,
  output logic [7:0]        r4015,
  output logic              wr400c,
  output logic              wr400e,
  output logic              wr400f,
  output logic              len_load,
  output logic              len_clear
);
  state_t      r_state;
  state_t      w_next;
  logic [15:0] w_ofs;
  logic        w_acc;
  logic        w_wr0c, w_wr0e, w_wr0f, w_wr15, w_rd15;
  logic [7:0]  r_400c, r_400e, r_400f, r_4015, r_rdata;
  logic        r_wr0c, r_wr0e, r_wr0f, r_ld, r_clr, r_rvalid;
  // addresses below the base wrap to huge offsets and so match nothing
  assign w_ofs  = bus.cpu_addr - BASE_ADDR;
  assign w_acc  = bus.cpu_valid && bus.cpu_ready;
  assign w_wr0c = w_acc && bus.cpu_we && w_ofs == OFS_400C;
  assign w_wr0e = w_acc && bus.cpu_we && w_ofs == OFS_400E;
  assign w_wr0f = w_acc && bus.cpu_we && w_ofs == OFS_400F;
  assign w_wr15 = w_acc && bus.cpu_we && w_ofs == OFS_4015;
  assign w_rd15 = w_acc && !bus.cpu_we && w_ofs == OFS_4015;
  // state register
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  // next state: any accepted access takes exactly one response cycle
  always_comb
    w_next = (r_state == IDLE && w_acc) ? RESP : IDLE;
  // ready only in IDLE and never while reset is held
  always_comb
    bus.cpu_ready = !rst && r_state == IDLE;
  // register file plus pulses that live only for the response cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_400c   <= 8'h00;
      r_400e   <= 8'h00;
      r_400f   <= 8'h00;
      r_4015   <= 8'h00;
      r_rdata  <= 8'h00;
      r_wr0c   <= 1'b0;
      r_wr0e   <= 1'b0;
      r_wr0f   <= 1'b0;
      r_ld     <= 1'b0;
      r_clr    <= 1'b0;
      r_rvalid <= 1'b0;
    end else begin
      r_400c   <= w_wr0c ? bus.cpu_wdata : r_400c;
      r_400e   <= w_wr0e ? bus.cpu_wdata : r_400e;
      r_400f   <= w_wr0f ? bus.cpu_wdata : r_400f;
      r_4015   <= w_wr15 ? bus.cpu_wdata : r_4015;
      r_wr0c   <= w_wr0c;
      r_wr0e   <= w_wr0e;
      r_wr0f   <= w_wr0f;
      r_ld     <= w_wr0f && r_4015[NOISE_EN_BIT];
      r_clr    <= w_wr15 && !bus.cpu_wdata[NOISE_EN_BIT];
      r_rvalid <= w_acc && !bus.cpu_we;
      r_rdata  <= w_rd15 ? status_byte(noise_len_nz) : 8'h00;
    end
  end
  assign r400c          = r_400c;
  assign r400e          = r_400e;
  assign r400f          = r_400f;
  assign r4015          = r_4015;
  assign wr400c         = r_wr0c;
  assign wr400e         = r_wr0e;
  assign wr400f         = r_wr0f;
  assign len_load       = r_ld;
  assign len_clear      = r_clr;
  assign bus.cpu_rvalid = r_rvalid;
  assign bus.cpu_rdata  = r_rdata;
endmodule

// File: tb/tb_apu_noise_regs.sv
// tb_apu_noise_regs: scoreboard bench for apu_noise_regs
module tb_apu_noise_regs;
  typedef struct {
    logic       rvalid;
    logic [7:0] rdata;
    logic       w0c, w0e, w0f, ld, clr;
    logic [7:0] c, e, f, s;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       nz = 1'b0;
  logic [7:0] r400c, r400e, r400f, r4015;
  logic       wr400c, wr400e, wr400f, len_load, len_clear;
  logic [7:0] m_c, m_e, m_f, m_s;
  int         n_checks = 0;
  int         n_errors = 0;
  int         acc_cnt = 0;
  exp_t       q[$];
  exp_t       mon_x;
  apu_noise_regs_if bus();
  apu_noise_regs #(.BASE_ADDR(16'h4000)) dut (
    .clk(clk), .rst(rst), .bus(bus), .noise_len_nz(nz),
    .r400c(r400c), .r400e(r400e), .r400f(r400f), .r4015(r4015),
    .wr400c(wr400c), .wr400e(wr400e), .wr400f(wr400f),
    .len_load(len_load), .len_clear(len_clear)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic push_exp(input logic we, input logic [15:0] addr, input logic [7:0] wd);
    exp_t x;
    logic [15:0] ofs;
    ofs = addr - 16'h4000;
    x = '{default: '0};
    if (we) begin
      if (ofs == 16'h000C) begin m_c = wd; x.w0c = 1'b1; end
      if (ofs == 16'h000E) begin m_e = wd; x.w0e = 1'b1; end
      if (ofs == 16'h000F) begin m_f = wd; x.w0f = 1'b1; x.ld = m_s[3]; end
      if (ofs == 16'h0015) begin m_s = wd; x.clr = !wd[3]; end
    end else begin
      x.rvalid = 1'b1;
      x.rdata = (ofs == 16'h0015) ? {4'b0, nz, 3'b0} : 8'h00;
    end
    x.c = m_c; x.e = m_e; x.f = m_f; x.s = m_s;
    q.push_back(x);
  endtask
  task automatic access(input logic we, input logic [15:0] addr, input logic [7:0] wd);
    logic got;
    bus.cpu_valid = 1'b1;
    bus.cpu_we = we;
    bus.cpu_addr = addr;
    bus.cpu_wdata = wd;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = bus.cpu_ready;
    end
    if (!got) check("ready_timeout", 8'd0, 8'd1);
    else push_exp(we, addr, wd);
    @(posedge clk);
    #1 bus.cpu_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask
  // scoreboard: each response cycle pops one prediction; idle cycles must be pulse-free
  always @(negedge clk) begin
    if (!rst) begin
      if (!bus.cpu_ready) begin
        if (q.size() == 0) check("sb_underflow", 8'd1, 8'd0);
        else begin
          mon_x = q.pop_front();
          check("rvalid", 8'(bus.cpu_rvalid), 8'(mon_x.rvalid));
          check("rdata", bus.cpu_rdata, mon_x.rdata);
          check("wr400c", 8'(wr400c), 8'(mon_x.w0c));
          check("wr400e", 8'(wr400e), 8'(mon_x.w0e));
          check("wr400f", 8'(wr400f), 8'(mon_x.w0f));
          check("len_load", 8'(len_load), 8'(mon_x.ld));
          check("len_clear", 8'(len_clear), 8'(mon_x.clr));
          check("r400c", r400c, mon_x.c);
          check("r400e", r400e, mon_x.e);
          check("r400f", r400f, mon_x.f);
          check("r4015", r4015, mon_x.s);
        end
      end else begin
        check("idle_pulses", 8'({bus.cpu_rvalid, wr400c, wr400e, wr400f, len_load, len_clear}), 8'd0);
        check("idle_rdata", bus.cpu_rdata, 8'h00);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.cpu_valid = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 16'h0000;
    bus.cpu_wdata = 8'h00;
    {m_c, m_e, m_f, m_s} = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 8'(bus.cpu_ready), 8'd0);
    check("rst_regs", r400c | r400e | r400f | r4015, 8'h00);
    check("rst_pulses", 8'({bus.cpu_rvalid, wr400c, wr400e, wr400f, len_load, len_clear}), 8'd0);
    check("rst_rdata", bus.cpu_rdata, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rel_ready", 8'(bus.cpu_ready), 8'd1);
    @(posedge clk);
    #1;
    access(1'b1, 16'h4015, 8'h08);
    access(1'b1, 16'h400F, 8'hA8);
    access(1'b1, 16'h4015, 8'h00);
    access(1'b1, 16'h400F, 8'h18);
    nz = 1'b1;
    access(1'b0, 16'h4015, 8'h00);
    access(1'b0, 16'h400C, 8'h00);
    nz = 1'b0;
    access(1'b0, 16'h4015, 8'h00);
    access(1'b1, 16'h400D, 8'h55);
    access(1'b1, 16'h3FFF, 8'h77);
    access(1'b1, 16'h400C, 8'h3C);
    access(1'b1, 16'h400E, 8'h5A);
    access(1'b1, 16'h4015, 8'h0F);
    access(1'b1, 16'h400F, 8'hF1);
    for (int i = 0; i < 6; i++) begin
      bus.cpu_valid = 1'b1;
      bus.cpu_we = 1'b1;
      bus.cpu_addr = 16'h400C;
      bus.cpu_wdata = 8'(8'h10 + i);
      @(negedge clk);
      check("burst_ready", 8'(bus.cpu_ready), 8'(i % 2 == 0));
      if (bus.cpu_ready) acc_cnt++;
      if (i % 2 == 0) push_exp(1'b1, 16'h400C, bus.cpu_wdata);
      @(posedge clk);
      #1;
    end
    bus.cpu_valid = 1'b0;
    check("burst_accepts", 8'(acc_cnt), 8'd3);
    @(negedge clk);
    check("burst_r400c", r400c, 8'h14);
    @(posedge clk);
    #1;
    bus.cpu_valid = 1'b1;
    bus.cpu_we = 1'b1;
    bus.cpu_addr = 16'h400E;
    bus.cpu_wdata = 8'hC3;
    @(negedge clk);
    push_exp(1'b1, 16'h400E, 8'hC3);
    @(posedge clk);
    #1 bus.cpu_valid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid_wr400e", 8'(wr400e), 8'd0);
    check("rstmid_r400e", r400e, 8'h00);
    check("rstmid_r400c", r400c, 8'h00);
    check("rstmid_r4015", r4015, 8'h00);
    check("rstmid_ready", 8'(bus.cpu_ready), 8'd0);
    {m_c, m_e, m_f, m_s} = '0;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_idle", 8'(bus.cpu_ready), 8'd1);
    @(posedge clk);
    #1;
    access(1'b1, 16'h400F, 8'h01);
    repeat (2) @(posedge clk);
    check("sb_empty", 8'(q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
